// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM encoding and prescaler derivation.
package uart_rx_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int OVERSAMPLE = 16;

  // Clocks per oversampling tick; integer truncation makes the receiver run slightly fast.
  function automatic int tick_div(input int clk_freq, input int baud_rate,
                                  input int oversample = OVERSAMPLE);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling prescaler: one-clock tick every TICK_DIV clocks while enabled.
// The counter is held at zero when disabled so the tick phase restarts with each frame.
module uart_baud_tick #(
  parameter int TICK_DIV = 54
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear when disabled, wrap after LAST, tick on the wrap cycle.
  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with internal 16x oversampling and one-cycle valid / frame-error strobes.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  import uart_rx_pkg::*;

  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);

  logic       rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [1:0] state_q, state_d;
  logic [3:0] os_cnt_q, os_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       dv_q, dv_d;
  logic       fe_q, fe_d;
  logic       tick;
  logic       fall;

  uart_baud_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q != IDLE),
    .tick  (tick)
  );

  // Two-flop synchronizer plus one history flop for edge detection; all idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  assign fall = rxd_prev_q && !rxd_s2_q;

  // Frame FSM: start qualification at mid start bit, then one sample per bit period.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
    case (state_q)
      IDLE: begin
        os_cnt_d  = 4'd0;
        bit_cnt_d = 3'd0;
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt_q == 4'd7) begin
            os_cnt_d = 4'd0;
            // A line already back high at mid start bit was a glitch.
            state_d  = rxd_s2_q ? IDLE : DATA;
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            shift_d   = {rxd_s2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            state_d = IDLE;
            if (rxd_s2_q) begin
              data_d = shift_q;
              dv_d   = 1'b1;
            end else begin
              fe_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      os_cnt_q  <= 4'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the serial link: recovers 8N1 bytes from the asynchronous `rxd` line, runs entirely on the 100 MHz system clock and generates its own 16× oversampling tick internally. It is the receiving counterpart of the baud-rate divider and transmitter side of the link. It sits between the board RX pin and the frame/pixel buffer logic, and delivers each byte with a one-cycle valid strobe.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency, Hz.
- `BAUD_RATE`, 115200: line rate, bits/s.
- `OVERSAMPLE`, 16: ticks per bit. Fixed at 16; the value is not checked.
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial input, idle high, asynchronous to `clk`.
- `data` out 8: last correctly framed byte.
- `data_valid` out 1: one-cycle pulse when `data` updates.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `busy` out 1: high while a frame is in progress (any state other than IDLE).

## Operation
- **Input synchronizer**
  - `rxd` passes through a 2-flop synchronizer before any use.
  - Synchronizer flops reset to 1.
  - A falling edge is detected on the synchronized value (previous 1, current 0).
- **Tick generator**
  - Divisor `TICK_DIV = CLK_FREQ/(BAUD_RATE*16)`, integer truncation. Default value 54.
  - Gives 864 clk per bit, about 0.47 % fast, within tolerance.
  - Counts 0..TICK_DIV-1 and asserts `tick` for one clk at wrap.
  - Held at 0 in IDLE, so the tick phase aligns to the start edge.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** on a synchronized falling edge, go to START and clear the tick counter `os_cnt` (4 bit).
  - **START:** on the tick where `os_cnt==7` (mid start bit):
    - If the line is 0, clear `os_cnt` and go to DATA.
    - If the line is 1, it was a glitch: return to IDLE with no output.
  - **DATA:** on the tick where `os_cnt==15`:
    - Sample the line into the shift register, LSB first.
    - Increment `bit_cnt` (3 bit).
    - After bit 7 is sampled, go to STOP.
  - **STOP:** on the tick where `os_cnt==15`:
    - If the line is 1, load `data` from the shift register and pulse `data_valid`.
    - If the line is 0, pulse `frame_err` and leave `data` unchanged.
    - Return to IDLE in either case.
- A new frame requires a fresh falling edge. After a frame error with the line held low (break), nothing is received until the line returns high and falls again.
- A falling edge during START, DATA or STOP is ignored.

## Timing
- **Reset values:** `data`=0x00, `data_valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, all counters 0.
- **Edge detection:** the synchronized falling edge is seen 2–3 clk after the pin edge.
- **Start check:** mid-start check is 8 ticks (432 clk) after detection.
- **Data samples:** bit *n* is sampled (8+16(n+1)) ticks after detection.
- **Stop sample:** 152 ticks (8208 clk) after detection.
- **Outputs:** `data_valid` or `frame_err` is registered and high in the clk following the stop-sample tick, for exactly 1 clk. `data` is stable from that same cycle until the next valid frame.
- **`busy`:** rises the clk after edge detection and falls together with the `data_valid`/`frame_err` pulse.
- **Back-to-back frames:** the receiver is back in IDLE about half a bit before the stop bit ends, so a start bit directly following the stop bit is caught.
- **Reset mid-frame:** all state clears immediately. No pulse is produced for the partial frame.
- `data_valid` and `frame_err` are never high in the same cycle.

## Structure
- **Shared package:** FSM state encoding (2-bit localparams IDLE=0, START=1, DATA=2, STOP=3), `TICK_DIV` derivation, `OVERSAMPLE`.
- **Sub-module `uart_baud_tick`:** the prescaler.
  - Inputs: `clk`, `rst_n`, `en`.
  - Output: `tick`.
  - Parameter: `TICK_DIV`.
  - Its counter clears when `en`=0.
- The synchronizer, FSM, shift register and output registers stay in `uart_rx`.

## Test plan
- **Single byte:** send 0x55 at 115200 baud → exactly one `data_valid` pulse, `data`=0x55, `frame_err` never asserted, `busy` low afterwards.
- **Back-to-back bytes:** send 0xA3, 0x00, 0xFF with zero idle gap → three `data_valid` pulses carrying 0xA3, 0x00, 0xFF in order.
- **Start glitch:** `rxd` low for 300 clk then high → no pulse, `busy` back to 0 within 432+3 clk; a following 0x3C frame is received correctly.
- **Framing error:** after a good 0x11 frame, send 0x7E with the stop bit driven low → one `frame_err` pulse, no `data_valid`, `data` stays 0x11.
- **Reset mid-frame:** assert `rst_n` low during bit 4 of a frame → outputs go to reset values immediately; after release and line idle, 0xC5 is received correctly.
- **Baud skew:** send 0x96 at bit periods of 847 clk and 881 clk (±2 %) → `data`=0x96 with `data_valid` in both cases.
